// File: rtl/adxl362_spi_pkg.sv
// Shared constants and state encoding for the ADXL362 SPI slave front-end.
// Command decode lives here so every consumer maps opcodes the same way.
package adxl362_spi_pkg;

   localparam logic [7:0] ADXL362_CMD_WRITE = 8'h0A;
   localparam logic [7:0] ADXL362_CMD_READ  = 8'h0B;
   localparam logic [7:0] ADXL362_CMD_FIFO  = 8'h0D;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CMD     = 3'd1,
      ST_ADDR_WR = 3'd2,
      ST_ADDR_RD = 3'd3,
      ST_LOAD    = 3'd4,
      ST_DATA_WR = 3'd5,
      ST_DATA_RD = 3'd6,
      ST_IGNORE  = 3'd7
   } spi_state_t;

   // FIFO reads and unknown opcodes are both swallowed by IGNORE
   function automatic spi_state_t cmd_decode(input logic [7:0] cmd);
      spi_state_t st;
      case (cmd)
         ADXL362_CMD_WRITE: st = ST_ADDR_WR;
         ADXL362_CMD_READ:  st = ST_ADDR_RD;
         default:           st = ST_IGNORE;
      endcase
      return st;
   endfunction

endpackage

// File: rtl/adxl362_spi_sync.sv
// Multi-flop synchroniser for one asynchronous SPI pin with registered
// one-cycle rise/fall strobes (latency STAGES+1 from the pin).
module adxl362_spi_sync #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pin,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain_r;
   logic              prev_r;
   logic              rise_r;
   logic              fall_r;

   // synchroniser chain, edge-history flop and registered strobes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain_r <= {STAGES{RESET_VAL}};
         prev_r  <= RESET_VAL;
         rise_r  <= 1'b0;
         fall_r  <= 1'b0;
      end else begin
         chain_r <= {chain_r[STAGES-2:0], pin};
         prev_r  <= chain_r[STAGES-1];
         rise_r  <= chain_r[STAGES-1] & ~prev_r;
         fall_r  <= ~chain_r[STAGES-1] & prev_r;
      end
   end

   assign level = chain_r[STAGES-1];
   assign rise  = rise_r;
   assign fall  = fall_r;

endmodule

// File: rtl/adxl362_spi_slave.sv
// ADXL362 SPI mode-0 slave: decodes 0x0A/0x0B commands, drives the register
// file write port and shifts read data out on MISO with address auto-increment.
module adxl362_spi_slave #(
   parameter int SYNC_STAGES = 2,
   parameter int WRITE_PULSE = 2
) (
   input  logic       clk_16mhz,
   input  logic       rst_n,
   input  logic       sclk,
   input  logic       cs_n,
   input  logic       mosi,
   output logic       miso,
   output logic       miso_oe,
   output logic       write,
   output logic [5:0] address,
   output logic [7:0] data_write,
   input  logic [7:0] data_read
);
   import adxl362_spi_pkg::*;

   localparam int PW = (WRITE_PULSE > 1) ? $clog2(WRITE_PULSE) : 1;

   logic sclk_level_s, sclk_rise_s, sclk_fall_s;
   logic cs_level_s, cs_rise_s, cs_fall_s;
   logic mosi_s, mosi_rise_s, mosi_fall_s;
   logic unused_s;

   spi_state_t state_r, state_nxt_s;
   logic [7:0]    rx_shift_r, tx_shift_r, rx_byte_s;
   logic [2:0]    bit_cnt_r;
   logic          sclk_rise_q_s, sclk_fall_q_s, byte_done_s;
   logic          miso_r, miso_oe_r, write_r, wr_start_r, inc_pend_r;
   logic [PW-1:0] pulse_cnt_r;
   logic [5:0]    address_r;
   logic [7:0]    data_write_r;

   adxl362_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
      .clk(clk_16mhz), .rst_n(rst_n), .pin(sclk),
      .level(sclk_level_s), .rise(sclk_rise_s), .fall(sclk_fall_s));
   adxl362_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
      .clk(clk_16mhz), .rst_n(rst_n), .pin(cs_n),
      .level(cs_level_s), .rise(cs_rise_s), .fall(cs_fall_s));
   adxl362_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
      .clk(clk_16mhz), .rst_n(rst_n), .pin(mosi),
      .level(mosi_s), .rise(mosi_rise_s), .fall(mosi_fall_s));

   assign unused_s      = &{1'b0, sclk_level_s, mosi_rise_s, mosi_fall_s};
   assign sclk_rise_q_s = sclk_rise_s & ~cs_level_s;
   assign sclk_fall_q_s = sclk_fall_s & ~cs_level_s;
   assign rx_byte_s     = {rx_shift_r[6:0], mosi_s};
   assign byte_done_s   = sclk_rise_q_s && (bit_cnt_r == 3'd7) &&
                          (state_r != ST_IDLE) && !cs_rise_s;

   // state register
   always_ff @(posedge clk_16mhz or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // next-state decode; cs_n release wins over everything
   always_comb begin
      state_nxt_s = state_r;
      if (cs_rise_s) begin
         state_nxt_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE:    if (cs_fall_s)   state_nxt_s = ST_CMD;     else state_nxt_s = ST_IDLE;
            ST_CMD:     if (byte_done_s) state_nxt_s = cmd_decode(rx_byte_s); else state_nxt_s = ST_CMD;
            ST_ADDR_WR: if (byte_done_s) state_nxt_s = ST_DATA_WR; else state_nxt_s = ST_ADDR_WR;
            ST_ADDR_RD: if (byte_done_s) state_nxt_s = ST_LOAD;    else state_nxt_s = ST_ADDR_RD;
            ST_LOAD:    state_nxt_s = ST_DATA_RD;
            ST_DATA_WR: state_nxt_s = ST_DATA_WR;
            ST_DATA_RD: if (byte_done_s) state_nxt_s = ST_LOAD;    else state_nxt_s = ST_DATA_RD;
            ST_IGNORE:  state_nxt_s = ST_IGNORE;
            default:    state_nxt_s = ST_IDLE;
         endcase
      end
   end

   // MOSI capture and bit counter; counter is cleared whenever the slave idles
   always_ff @(posedge clk_16mhz or negedge rst_n) begin
      if (!rst_n) begin
         rx_shift_r <= 8'h00;
         bit_cnt_r  <= 3'd0;
      end else if (state_nxt_s == ST_IDLE) begin
         bit_cnt_r  <= 3'd0;
      end else if (sclk_rise_q_s && (state_r != ST_IDLE)) begin
         rx_shift_r <= rx_byte_s;
         bit_cnt_r  <= bit_cnt_r + 3'd1;
      end
   end

   // MISO serialiser; the fall right after a byte's 8th rise (count 0) must
   // not shift, otherwise the freshly loaded MSB would be lost
   always_ff @(posedge clk_16mhz or negedge rst_n) begin
      if (!rst_n) begin
         tx_shift_r <= 8'h00;
         miso_r     <= 1'b0;
         miso_oe_r  <= 1'b0;
      end else begin
         miso_oe_r <= (state_nxt_s == ST_DATA_RD);
         if ((state_r == ST_LOAD) && (state_nxt_s == ST_DATA_RD)) begin
            tx_shift_r <= data_read;
            miso_r     <= data_read[7];
         end else if ((state_r == ST_DATA_RD) && (state_nxt_s == ST_DATA_RD) &&
                      sclk_fall_q_s && (bit_cnt_r != 3'd0)) begin
            tx_shift_r <= {tx_shift_r[6:0], 1'b0};
            miso_r     <= tx_shift_r[6];
         end else if ((state_nxt_s != ST_DATA_RD) && (state_nxt_s != ST_LOAD)) begin
            miso_r     <= 1'b0;
         end
      end
   end

   // register-file write strobe, data latch and address sequencing
   always_ff @(posedge clk_16mhz or negedge rst_n) begin
      if (!rst_n) begin
         address_r    <= 6'd0;
         data_write_r <= 8'h00;
         write_r      <= 1'b0;
         wr_start_r   <= 1'b0;
         inc_pend_r   <= 1'b0;
         pulse_cnt_r  <= '0;
      end else begin
         wr_start_r <= byte_done_s && (state_r == ST_DATA_WR);
         if (byte_done_s && (state_r == ST_DATA_WR)) begin
            data_write_r <= rx_byte_s;
         end
         if (wr_start_r) begin
            write_r     <= 1'b1;
            pulse_cnt_r <= PW'(WRITE_PULSE - 1);
            inc_pend_r  <= 1'b0;
         end else if (write_r) begin
            if (pulse_cnt_r == '0) begin
               write_r    <= 1'b0;
               inc_pend_r <= 1'b1;
            end else begin
               pulse_cnt_r <= pulse_cnt_r - PW'(1);
            end
         end else begin
            inc_pend_r <= 1'b0;
         end
         if (byte_done_s && ((state_r == ST_ADDR_WR) || (state_r == ST_ADDR_RD))) begin
            address_r <= rx_byte_s[5:0];
         end else if ((byte_done_s && (state_r == ST_DATA_RD)) || inc_pend_r) begin
            address_r <= address_r + 6'd1;
         end
      end
   end

   assign miso       = miso_r;
   assign miso_oe    = miso_oe_r;
   assign write      = write_r;
   assign address    = address_r;
   assign data_write = data_write_r;

endmodule

// File: tb/tb_adxl362_spi_slave.sv
// Self-checking bench for adxl362_spi_slave: SPI master, register-file model,
// read/write scoreboards and a transaction table plus corner-case sequences.
module tb_adxl362_spi_slave;

   localparam int SYNC_STAGES = 2;
   localparam int WRITE_PULSE = 2;
   localparam int HALF        = 8;

   logic       clk_16mhz = 1'b0;
   logic       rst_n     = 1'b0;
   logic       sclk      = 1'b0;
   logic       cs_n      = 1'b1;
   logic       mosi      = 1'b0;
   logic       miso, miso_oe, write;
   logic [5:0] address;
   logic [7:0] data_write, data_read;

   adxl362_spi_slave #(.SYNC_STAGES(SYNC_STAGES), .WRITE_PULSE(WRITE_PULSE)) dut (
      .clk_16mhz(clk_16mhz), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
      .miso(miso), .miso_oe(miso_oe), .write(write), .address(address),
      .data_write(data_write), .data_read(data_read));

   always #5 clk_16mhz = ~clk_16mhz;

   typedef struct {
      logic        is_read;
      logic [5:0]  addr;
      int          nbytes;
      logic [31:0] data;
      logic [5:0]  exp_addr;
   } vec_t;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          pulses   = 0;
   int          exp_pulses = 0;
   int          wr_width = 0;
   logic        write_prev = 1'b0;
   logic        mem_ready  = 1'b0;
   logic [7:0]  mem [64];
   logic [7:0]  rd_q [$];
   logic [13:0] wr_q [$];
   vec_t        vecs [7];

   assign data_read = mem[address];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // register-file model plus write scoreboard and pulse-width monitor
   always @(negedge clk_16mhz) begin
      write_prev <= write;
      if (!mem_ready) begin
         for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
         mem[0] <= 8'hAD; mem[1] <= 8'h1D; mem[2] <= 8'hF2; mem[3] <= 8'h01;
         mem_ready <= 1'b1;
      end else if (write && !write_prev) begin
         mem[address] <= data_write;
         pulses   <= pulses + 1;
         wr_width <= 1;
         if (wr_q.size() == 0) begin
            check("unexpected_write", 32'd1, 32'd0);
         end else begin
            logic [13:0] e;
            e = wr_q.pop_front();
            check("write_address", {26'd0, address}, {26'd0, e[13:8]});
            check("write_data", {24'd0, data_write}, {24'd0, e[7:0]});
         end
      end else if (write) begin
         wr_width <= wr_width + 1;
      end else if (write_prev) begin
         check("write_width", wr_width, WRITE_PULSE);
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk_16mhz);
   endtask

   task automatic spi_byte(input logic [7:0] tx, input int nbits, input logic exp_oe,
                           output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         mosi = tx[7-i];
         wait_clk(HALF);
         sclk = 1'b1;
         rx[7-i] = miso;
         check("miso_oe", {31'd0, miso_oe}, {31'd0, exp_oe});
         if (!exp_oe) check("miso_idle", {31'd0, miso}, 32'd0);
         wait_clk(HALF);
         sclk = 1'b0;
      end
   endtask

   task automatic cs_begin();
      cs_n = 1'b0;
      wait_clk(HALF);
   endtask

   task automatic cs_end();
      wait_clk(HALF);
      cs_n = 1'b1;
      wait_clk(3 * HALF);
   endtask

   task automatic run_vec(input vec_t v);
      logic [7:0] rx, b, exp;
      logic [5:0] a;
      cs_begin();
      spi_byte(v.is_read ? 8'h0B : 8'h0A, 8, 1'b0, rx);
      spi_byte({2'b00, v.addr}, 8, 1'b0, rx);
      for (int i = 0; i < v.nbytes; i++) begin
         b = v.data[31-8*i -: 8];
         a = v.addr + 6'(i);
         if (v.is_read) begin
            rd_q.push_back(b);
            spi_byte(8'h00, 8, 1'b1, rx);
            exp = rd_q.pop_front();
            check("read_byte", {24'd0, rx}, {24'd0, exp});
         end else begin
            wr_q.push_back({a, b});
            exp_pulses++;
            spi_byte(b, 8, 1'b0, rx);
         end
      end
      cs_end();
      check("end_address", {26'd0, address}, {26'd0, v.exp_addr});
      check("pulse_count", pulses, exp_pulses);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] rx;
      vecs[0] = '{1'b1, 6'h00, 1, 32'hAD000000, 6'h01};
      vecs[1] = '{1'b1, 6'h00, 4, 32'hAD1DF201, 6'h04};
      vecs[2] = '{1'b0, 6'h2D, 1, 32'h02000000, 6'h2E};
      vecs[3] = '{1'b1, 6'h2D, 1, 32'h02000000, 6'h2E};
      vecs[4] = '{1'b0, 6'h3F, 2, 32'h11220000, 6'h01};
      vecs[5] = '{1'b1, 6'h3F, 2, 32'h11220000, 6'h01};
      vecs[6] = '{1'b1, 6'h20, 1, 32'h00000000, 6'h21};

      wait_clk(4);
      check("rst_miso", {31'd0, miso}, 32'd0);
      check("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
      check("rst_write", {31'd0, write}, 32'd0);
      check("rst_address", {26'd0, address}, 32'd0);
      check("rst_data_write", {24'd0, data_write}, 32'd0);
      rst_n = 1'b1;
      wait_clk(4);

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // abort mid-byte during a write: no pulse, value at 0x20 untouched
      cs_begin();
      spi_byte(8'h0A, 8, 1'b0, rx);
      spi_byte(8'h20, 8, 1'b0, rx);
      spi_byte(8'hFF, 5, 1'b0, rx);
      cs_end();
      check("abort_no_write", pulses, exp_pulses);
      check("abort_miso_oe", {31'd0, miso_oe}, 32'd0);
      run_vec(vecs[6]);

      // illegal command: MISO stays quiet and nothing is written
      cs_begin();
      spi_byte(8'h55, 8, 1'b0, rx);
      spi_byte(8'hFF, 8, 1'b0, rx);
      spi_byte(8'hFF, 8, 1'b0, rx);
      cs_end();
      check("illegal_no_write", pulses, exp_pulses);

      // reset in the middle of a read data byte
      cs_begin();
      spi_byte(8'h0B, 8, 1'b0, rx);
      spi_byte(8'h03, 8, 1'b0, rx);
      spi_byte(8'h00, 4, 1'b1, rx);
      rst_n = 1'b0;
      #1;
      check("midrst_miso", {31'd0, miso}, 32'd0);
      check("midrst_miso_oe", {31'd0, miso_oe}, 32'd0);
      check("midrst_write", {31'd0, write}, 32'd0);
      check("midrst_address", {26'd0, address}, 32'd0);
      check("midrst_data_write", {24'd0, data_write}, 32'd0);
      cs_n = 1'b1;
      wait_clk(4);
      rst_n = 1'b1;
      wait_clk(4);
      run_vec('{1'b1, 6'h01, 1, 32'h1D000000, 6'h02});

      check("write_queue_empty", wr_q.size(), 32'd0);
      check("total_pulses", pulses, 32'd3);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/adxl362_spi_slave.md
Name: adxl362_spi_slave

Overview:
SPI slave front-end of the ADXL362 behavioural model, sitting directly upstream of the register file. It oversamples the host SPI pins (mode 0, CPOL=0/CPHA=0) in the clk_16mhz domain and decodes the ADXL362 command protocol: 0x0A write, 0x0B read. It drives the register file's write/address/data_write inputs and serialises its data_read output back onto MISO, with address auto-increment for burst transfers.

Parameters:
SYNC_STAGES, 2, flops in each pin synchroniser (sclk, cs_n, mosi); minimum 2.
WRITE_PULSE, 2, clk_16mhz cycles that write is held high per written byte; minimum 1.

Ports:
clk_16mhz  input  1  system clock; all logic on its rising edge.
rst_n  input  1  asynchronous, active-low reset.
sclk  input  1  SPI clock from host, asynchronous; at most clk_16mhz/8.
cs_n  input  1  SPI chip select, active low, asynchronous.
mosi  input  1  SPI data in, MSB first.
miso  output  1  SPI data out, MSB first; 0 when not reading.
miso_oe  output  1  1 while cs_n is low and state is DATA_RD; used by the top level to tri-state miso.
write  output  1  register write strobe; the register file captures on its rising edge.
address  output  6  register address (low 6 bits of the SPI address byte).
data_write  output  8  write data to the register file.
data_read  input  8  combinational read data from the register file for the current address.

Behaviour:
- Reset is asynchronous and active-low. Reset values: state IDLE, miso 0, miso_oe 0, write 0, address 0, data_write 0, bit counter 0, synchronisers 1 for cs_n and 0 for sclk/mosi.
- Synchronisation: each pin passes through SYNC_STAGES flops. Edge detect compares the last stage with one extra flop. Rise/fall strobes are one cycle wide, with latency SYNC_STAGES+1 from the pin.
- Bit capture: shift mosi into an 8-bit shift register on each synchronised sclk rise. The bit counter runs 0..7; the byte completes on the 8th rise.
- States:
  - IDLE: wait for a cs_n fall, then go to CMD with the counter cleared.
  - CMD: on byte complete, 0x0A goes to ADDR_WR, 0x0B goes to ADDR_RD, any other value goes to IGNORE.
  - ADDR_WR: on byte complete, address <= byte[5:0]; go to DATA_WR.
  - ADDR_RD: on byte complete, address <= byte[5:0]; go to LOAD, one cycle for data_read to settle.
  - LOAD: load data_read into the tx shift register, set miso = bit 7, miso_oe = 1; go to DATA_RD.
  - DATA_WR: on byte complete, data_write <= byte. On the next cycle write goes high for WRITE_PULSE cycles, then low. On the cycle after write falls, address <= address+1. Stay in DATA_WR.
  - DATA_RD: on each sclk fall, shift the tx register left and drive the new MSB onto miso. After the 8th sclk rise, address <= address+1; on the next cycle go to LOAD for the next byte.
  - IGNORE: discard all bits; miso held 0.
- cs_n rise, in any state: return to IDLE and clear the bit counter and miso_oe. A partial byte is discarded with no write. A write pulse already in progress completes its full WRITE_PULSE width. The address holds its last value.
- address increments modulo 64 (6'h3F wraps to 6'h00).
- data_write and address are stable for at least one cycle before the write rise and throughout the high time.
- MISO timing: the new bit appears SYNC_STAGES+2 cycles after the sclk pin falls, which is within one half period at the maximum sclk rate.
- An sclk edge while cs_n is high is ignored.
- Reset asserted mid-transfer: immediate return to reset values. The host must restart the transfer with a new cs_n fall.

Decomposition:
- Shared package/header adxl362_spi_pkg.vh holds the command constants (ADXL362_CMD_WRITE 8'h0A, ADXL362_CMD_READ 8'h0B, ADXL362_CMD_FIFO 8'h0D, treated as IGNORE) and the state encodings.
- Register addresses continue to come from adxl362_registers.vh.
- One sub-module, adxl362_spi_sync: an SYNC_STAGES-deep synchroniser plus rise/fall detect for one bit, instantiated three times.

Test Plan:
- Read DEVID: cs_n low, send 0x0B, 0x00, then 8 dummy clocks. Required: MISO returns 0xAD, miso_oe is 1 only during the data byte, write never pulses.
- Burst read: send 0x0B, 0x00, then 32 clocks. Required: bytes 0xAD, 0x1D, 0xF2, 0x01 in order; address ends at 6'h04.
- Single write: send 0x0A, 0x2D, 0x02. Required: one write pulse of WRITE_PULSE cycles with address=6'h2D and data_write=0x02. A following read of 0x2D returns 0x02.
- Burst write with wrap: send 0x0A, 0x3F, 0x11, 0x22. Required: write to 0x3F with data 0x11, then to 0x00 with data 0x22, exactly two pulses.
- Abort: send 0x0A, 0x20, then 5 bits of 0xFF, then cs_n high. Required: no write pulse and state back to IDLE. A new 0x0B, 0x20 read returns the unchanged value.
- Illegal command and reset: send command 0x55 followed by 16 clocks. Required: miso 0, miso_oe 0, no write. Then assert rst_n low mid-byte of a valid read. Required: all outputs return to reset values immediately.
